// File: rtl/dc_pkg.sv
// Shared types and constants for the operand issue queue and its ALU neighbour.
package dc_pkg;
  localparam int DC_DATA_W = 8;
  localparam int DC_SEL_W  = 4;

  // Select code the ALU decodes as "idle"; it then produces DC_IDLE_RESULT.
  localparam logic [DC_SEL_W-1:0]  DC_SEL_IDLE    = 4'h0;
  localparam logic [DC_DATA_W-1:0] DC_IDLE_RESULT = 8'h55;

  typedef struct packed {
    logic [DC_DATA_W-1:0] a;
    logic [DC_DATA_W-1:0] b;
    logic [DC_SEL_W-1:0]  sel;
  } dc_op_t;
endpackage

// File: rtl/dc_sync_fifo.sv
// Generic synchronous FIFO; full/empty come from an occupancy counter so pointer wrap is transparent.
module dc_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 20,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // No bypass: a full queue refuses a push even when a pop happens on the same edge.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/dc_op_issue_queue.sv
// Operand issue queue feeding the ALU: in-order buffering, idle-code head muxing, saturating issue count.
module dc_op_issue_queue
  import dc_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  localparam int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [3:0]        in_sel,
  input  logic              flush,
  output logic [DATA_W-1:0] dcin_a,
  output logic [DATA_W-1:0] dcin_b,
  output logic [3:0]        dc_select,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  issued_count
);
  dc_op_t           wr_op, head_op;
  logic             full, empty, pop;
  logic [CNT_W-1:0] issued_q, issued_d;

  assign wr_op = '{a: in_a, b: in_b, sel: in_sel};

  dc_sync_fifo #(.DEPTH(DEPTH), .W($bits(dc_op_t))) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .pop_i   (out_ready),
    .flush_i (flush),
    .wdata_i (wr_op),
    .rdata_o (head_op),
    .full_o  (full),
    .empty_o (empty),
    .count_o (occupancy)
  );

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign pop       = !empty && out_ready && !flush;

  // Storage is don't-care when empty, so the ALU sees the idle code instead.
  always_comb begin
    dcin_a    = '0;
    dcin_b    = '0;
    dc_select = DC_SEL_IDLE;
    if (!empty) begin
      dcin_a    = head_op.a;
      dcin_b    = head_op.b;
      dc_select = head_op.sel;
    end
  end

  always_comb begin
    issued_d = issued_q;
    if (pop && (issued_q != '1)) issued_d = issued_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) issued_q <= '0;
    else     issued_q <= issued_d;
  end

  assign issued_count = issued_q;
endmodule

// File: doc/dc_op_issue_queue.md
# dc_op_issue_queue

Operand issue queue directly upstream of the nested-select combinational ALU stage. It accepts (a, b, select) operation tuples over a valid/ready handshake, buffers up to DEPTH of them in order, and presents the head entry on the ALU's input ports (dcin_a, dcin_b, dc_select) with its own valid/ready pair. Used to decouple a bursty operation producer from the downstream ALU/result consumer and to give the ALU a defined idle code when nothing is pending.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- DATA_W, 8: operand width; ALU stage is fixed at 8.
- CNT_W, 16: width of the issued-operation counter.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a tuple on in_a/in_b/in_sel.
- in_ready  output  1  queue can accept; equals !full.
- in_a  input  DATA_W  operand A.
- in_b  input  DATA_W  operand B.
- in_sel  input  4  ALU select code.
- flush  input  1  discard all queued entries.
- dcin_a  output  DATA_W  head operand A to ALU.
- dcin_b  output  DATA_W  head operand B to ALU.
- dc_select  output  4  head select code to ALU.
- out_valid  output  1  head entry is valid; equals !empty.
- out_ready  input  1  consumer has taken the ALU result this cycle.
- occupancy  output  $clog2(DEPTH)+1  entries currently held.
- issued_count  output  CNT_W  completed pops since reset, saturating.

## Operation
- Push: in_valid && in_ready at a clock edge writes the tuple at wr_ptr, increments wr_ptr modulo DEPTH.
- Pop: out_valid && out_ready at a clock edge increments rd_ptr modulo DEPTH and issued_count (holds at all-ones).
- Simultaneous push and pop: both happen; occupancy unchanged. When full, in_ready=0 even if out_ready=1 (no same-cycle bypass into a full queue).
- out_ready with queue empty: ignored; no pointer or counter change.
- in_valid while full: ignored; producer must hold the tuple until in_ready.
- Flush: resets rd_ptr, wr_ptr and occupancy to 0 on the edge; takes priority over a same-cycle push and pop (neither takes effect, issued_count not incremented). issued_count is not cleared by flush.
- Head presentation: when !empty, dcin_a/dcin_b/dc_select show the entry at rd_ptr. When empty, they show the idle code: dcin_a=0, dcin_b=0, dc_select=4'h0. The ALU maps that code to 8'h55.
- Stability: while out_valid && !out_ready, dcin_a/dcin_b/dc_select are held constant. The queue performs no reordering and no operand modification.
- Divide-by-zero is not filtered here; the ALU guards it.

## Timing
- Reset values: in_ready=1, out_valid=0, dcin_a=0, dcin_b=0, dc_select=0, occupancy=0, issued_count=0. Storage contents are don't-care.
- Push-to-present latency: 1 cycle. An entry accepted at edge N drives out_valid and the ALU inputs after edge N, visible in cycle N+1.
- in_ready, out_valid, occupancy and the head outputs depend only on registered state. There is no combinational path from in_* or out_ready to any output.
- Full-to-ready: a pop at edge N raises in_ready in cycle N+1.
- Pointer wrap at DEPTH-1→0 is transparent; full/empty use the occupancy counter, not pointer equality alone.
- Reset asserted mid-burst: all state returns to reset values on that edge, and in-flight entries are lost.

## Structure
- Shared package dc_pkg holds:
  - DC_SEL_IDLE = 4'h0
  - DC_IDLE_RESULT = 8'h55
  - typedef dc_op_t struct {a, b, sel}, used for the storage array and bench transactions.
- One natural sub-module, dc_sync_fifo, a generic synchronous FIFO with occupancy output. dc_op_issue_queue instantiates it with dc_op_t entries and adds the idle-code muxing and issued_count.

## Test plan
- Reset then idle: rst for 2 cycles, no traffic → out_valid=0, dc_select=0, dcin_a=dcin_b=0, downstream result 8'h55, in_ready=1.
- Single op: push a=8'h12, b=8'h34, sel=4'hF with out_ready=0 → next cycle out_valid=1 and ALU result 8'h46, held stable for 3 cycles. Then out_ready=1 for one cycle → out_valid=0, issued_count=1.
- Fill and backpressure: DEPTH=4, push 5 tuples back-to-back with out_ready=0 → after the 4th, in_ready=0 and occupancy=4; the 5th is held. Then out_ready=1 → pops in push order, 5th accepted the cycle after first pop.
- Simultaneous push/pop at occupancy 2 over 8 cycles (pointer wrap) → occupancy stays 2, FIFO order preserved, issued_count=8.
- Flush with concurrent push and pop at occupancy 3 → occupancy=0, out_valid=0, issued_count unchanged, pushed tuple not stored.
- Saturation: CNT_W=4, perform 20 pops → issued_count=4'hF.
